// File: rtl/rx_frame_filter_pkg.sv
// rtl/rx_frame_filter_pkg.sv - shared types and helpers for the ingress frame filter
package rx_frame_filter_pkg;

    typedef enum logic {
        WR_ACCEPT,
        WR_DISCARD
    } wr_state_t;

    typedef enum logic [2:0] {
        DROP_NONE,
        DROP_OVERFLOW,
        DROP_ERROR,
        DROP_OVERSIZE,
        DROP_RUNT
    } drop_reason_t;

    localparam int BEAT_BYTES = 8;
    localparam int WORD_W     = BEAT_BYTES * 8 + BEAT_BYTES + 1;

    // Packet byte count add that pins at 0xFFFF instead of wrapping
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/rx_frame_filter_mem.sv
// rtl/rx_frame_filter_mem.sv - beat storage with synchronous write and async read
module frame_store_mem
    import rx_frame_filter_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WORD_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Write one {last, keep, data} word per accepted stored beat
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_frame_filter.sv
// rtl/rx_frame_filter.sv - store-and-forward ingress filter dropping bad packets
module rx_frame_filter
    import rx_frame_filter_pkg::*;
#(
    parameter int DEPTH           = 256,
    parameter int MIN_PACKET_SIZE = 64,
    parameter int MAX_PACKET_SIZE = 1500
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic [63:0]              in_data,
    input  logic [7:0]               in_keep,
    input  logic                     in_last,
    input  logic                     in_error,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [63:0]              out_data,
    output logic [7:0]               out_keep,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [31:0]              good_packet_count,
    output logic [31:0]              runt_count,
    output logic [31:0]              oversize_count,
    output logic [31:0]              error_count,
    output logic [31:0]              overflow_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] ONE     = PW'(1);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [15:0]   MIN_B   = 16'(MIN_PACKET_SIZE);
    localparam logic [15:0]   MAX_B   = 16'(MAX_PACKET_SIZE);

    wr_state_t    state, state_nxt;
    drop_reason_t reason, reason_nxt, pkt_reason, verdict;
    logic [PW-1:0] wr_ptr, wr_ptr_nxt, commit_ptr, commit_nxt, rd_ptr, rd_nxt;
    logic [15:0]   acc, acc_nxt, bytes_sum;
    logic          err_flag, err_nxt, mem_we, verdict_valid;
    logic          beat_acc, full, rd_fire;
    logic [3:0]    keep_bytes;
    logic [WORD_W-1:0] rd_word;

    assign in_ready   = enable & rst_n;
    assign beat_acc   = in_valid & enable;
    // Registered rd_ptr: a read in the same cycle does not free space for this beat
    assign full       = ((wr_ptr - rd_ptr) == DEPTH_P);
    assign keep_bytes = 4'($countones(in_keep));
    assign bytes_sum  = sat_add(acc, keep_bytes);

    assign out_valid = (rd_ptr != commit_ptr);
    assign rd_fire   = out_valid & out_ready;
    assign rd_nxt    = rd_fire ? rd_ptr + ONE : rd_ptr;
    // Gate the raw memory word so outputs read zero whenever nothing is committed
    assign out_data  = out_valid ? rd_word[63:0]  : 64'd0;
    assign out_keep  = out_valid ? rd_word[71:64] : 8'd0;
    assign out_last  = out_valid ? rd_word[72]    : 1'b0;

    frame_store_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({in_last, in_keep, in_data}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_word)
    );

    // Write FSM next state: store, roll back on overflow/oversize, classify on last beat
    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        commit_nxt    = commit_ptr;
        reason_nxt    = reason;
        acc_nxt       = acc;
        err_nxt       = err_flag;
        mem_we        = 1'b0;
        pkt_reason    = reason;
        verdict       = DROP_NONE;
        verdict_valid = 1'b0;
        if (beat_acc) begin
            acc_nxt = bytes_sum;
            err_nxt = err_flag | in_error;
            if (state == WR_ACCEPT) begin
                if (full) begin
                    pkt_reason = DROP_OVERFLOW;
                    wr_ptr_nxt = commit_ptr;
                    state_nxt  = WR_DISCARD;
                end else begin
                    mem_we     = 1'b1;
                    wr_ptr_nxt = wr_ptr + ONE;
                    if (bytes_sum > MAX_B) begin
                        pkt_reason = DROP_OVERSIZE;
                        wr_ptr_nxt = commit_ptr;
                        state_nxt  = WR_DISCARD;
                    end
                end
            end
            reason_nxt = pkt_reason;
            if (in_last) begin
                verdict_valid = 1'b1;
                if (pkt_reason == DROP_OVERFLOW)      verdict = DROP_OVERFLOW;
                else if (err_nxt)                     verdict = DROP_ERROR;
                else if (pkt_reason == DROP_OVERSIZE) verdict = DROP_OVERSIZE;
                else if (bytes_sum < MIN_B)           verdict = DROP_RUNT;
                else                                  verdict = DROP_NONE;
                if (verdict == DROP_NONE) commit_nxt = wr_ptr + ONE;
                else                      wr_ptr_nxt = commit_ptr;
                acc_nxt    = 16'd0;
                err_nxt    = 1'b0;
                reason_nxt = DROP_NONE;
                state_nxt  = WR_ACCEPT;
            end
        end
    end

    // State, pointers and level registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WR_ACCEPT;
            reason     <= DROP_NONE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            acc        <= 16'd0;
            err_flag   <= 1'b0;
            fifo_level <= '0;
        end else begin
            state      <= state_nxt;
            reason     <= reason_nxt;
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_nxt;
            rd_ptr     <= rd_nxt;
            acc        <= acc_nxt;
            err_flag   <= err_nxt;
            fifo_level <= commit_nxt - rd_nxt;
        end
    end

    // One statistics counter bumps per classified packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_packet_count <= 32'd0;
            runt_count        <= 32'd0;
            oversize_count    <= 32'd0;
            error_count       <= 32'd0;
            overflow_count    <= 32'd0;
        end else if (verdict_valid) begin
            case (verdict)
                DROP_NONE:     good_packet_count <= good_packet_count + 32'd1;
                DROP_RUNT:     runt_count        <= runt_count + 32'd1;
                DROP_OVERSIZE: oversize_count    <= oversize_count + 32'd1;
                DROP_ERROR:    error_count       <= error_count + 32'd1;
                default:       overflow_count    <= overflow_count + 32'd1;
            endcase
        end
    end

endmodule
